axi_reset_sequencer: RTL and testbench

- Sequences core reset release and re-assertion for the Rocket Top instance, driven from mmcm_locked and a software soft-reset request.
- Gates new AR/AW requests on the PS DDR slave (mem AXI) port while quiescing.
- Counts outstanding read and write bursts so reset is never asserted with DDR transactions in flight.
- Sits in the wrapper between the MMCM/PS reset sources and Top's reset input, snooping the mem AXI handshakes.

---
 rtl/axi_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_axi_reset_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reset_sequencer.sv
// Core reset sequencer that quiesces the mem AXI port before reset.
// Define RSTSEQ_DRAIN_TIMEOUT_EN to bound the DRAIN phase.
module axi_reset_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 5,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             mmcm_locked,
  input  logic             soft_reset_req,
  input  logic             ar_fire,
  input  logic             r_last_fire,
  input  logic             aw_fire,
  input  logic             b_fire,
  output logic             core_reset,
  output logic             axi_gate,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             proto_err,
  output logic             drain_timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    LOCKWAIT = 2'd0,
    HOLD     = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } st_t;

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  st_t              cur;
  st_t              nxt;
  logic             lock_q;
  logic             lock_s;
  logic [HW-1:0]    hold_cnt;
  logic             drain_empty;
  logic             tmo_hit;
  logic             tmo_set;
  logic             cnt_en;
  logic [CNT_W:0]   rd_upd;
  logic [CNT_W:0]   wr_upd;

  // Returns {error, next value}; saturates at both ends.
  function automatic logic [CNT_W:0] bump(
    input logic [CNT_W-1:0] v,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W:0] r;
    r = {1'b0, v};
    if (inc && !dec) begin
      if (v == CMAX) r = {1'b1, v};
      else           r = {1'b0, v + 1'b1};
    end else if (dec && !inc) begin
      if (v == '0) r = {1'b1, v};
      else         r = {1'b0, v - 1'b1};
    end
    return r;
  endfunction

  assign drain_empty = (rd_outstanding == '0) &&
                       (wr_outstanding == '0);
  assign cnt_en = (cur == RUN) || (cur == DRAIN);
  assign rd_upd = bump(rd_outstanding, ar_fire,
                       r_last_fire);
  assign wr_upd = bump(wr_outstanding, aw_fire,
                       b_fire);
  assign state  = cur;

`ifdef RSTSEQ_DRAIN_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0] DLAST =
    DW'(DRAIN_TIMEOUT - 1);

  logic [DW-1:0] drain_cnt;

  assign tmo_hit = (drain_cnt == DLAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt <= '0;
    end else if (cur != DRAIN) begin
      drain_cnt <= '0;
    end else if (!tmo_hit) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign tmo_set = (cur == DRAIN) && lock_s &&
                   !drain_empty && tmo_hit;

  always_comb begin
    nxt = cur;
    unique case (cur)
      LOCKWAIT: begin
        if (lock_s) nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)                    nxt = LOCKWAIT;
        else if (hold_cnt == HOLD_LAST) nxt = RUN;
      end
      // Lock loss skips the drain: the clock is not trusted.
      RUN: begin
        if (!lock_s)             nxt = LOCKWAIT;
        else if (soft_reset_req) nxt = DRAIN;
      end
      DRAIN: begin
        if (!lock_s)          nxt = LOCKWAIT;
        else if (drain_empty) nxt = HOLD;
        else if (tmo_hit)     nxt = HOLD;
      end
      default: nxt = LOCKWAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur            <= LOCKWAIT;
      lock_q         <= 1'b0;
      lock_s         <= 1'b0;
      hold_cnt       <= '0;
      core_reset     <= 1'b1;
      axi_gate       <= 1'b1;
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      proto_err      <= 1'b0;
      drain_timeout  <= 1'b0;
    end else begin
      lock_q     <= mmcm_locked;
      lock_s     <= lock_q;
      cur        <= nxt;
      core_reset <= (nxt == LOCKWAIT) || (nxt == HOLD);
      axi_gate   <= (nxt != RUN);
      if ((cur == HOLD) && (nxt == HOLD))
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
      // Burst counts only live while the core runs.
      if (cnt_en) begin
        rd_outstanding <= rd_upd[CNT_W-1:0];
        wr_outstanding <= wr_upd[CNT_W-1:0];
        proto_err      <= proto_err | rd_upd[CNT_W] |
                          wr_upd[CNT_W];
      end else begin
        rd_outstanding <= '0;
        wr_outstanding <= '0;
      end
      drain_timeout <= drain_timeout | tmo_set;
    end
  end

endmodule

// File: tb/tb_axi_reset_sequencer.sv
// Randomised bench for axi_reset_sequencer with a behavioural model.
// Covers power-up, drain, lock loss, saturation and async reset.
module tb_axi_reset_sequencer;

  localparam int HOLD = 16;
  localparam int CW   = 3;
  localparam int DTO  = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef RSTSEQ_DRAIN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          mmcm_locked = 1'b0;
  logic          soft_reset_req = 1'b0;
  logic          ar_fire = 1'b0;
  logic          r_last_fire = 1'b0;
  logic          aw_fire = 1'b0;
  logic          b_fire = 1'b0;
  logic          core_reset;
  logic          axi_gate;
  logic [CW-1:0] rd_outstanding;
  logic [CW-1:0] wr_outstanding;
  logic          proto_err;
  logic          drain_timeout;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axi_reset_sequencer #(
    .HOLD_CYCLES  (HOLD),
    .CNT_W        (CW),
    .DRAIN_TIMEOUT(DTO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mmcm_locked   (mmcm_locked),
    .soft_reset_req(soft_reset_req),
    .ar_fire       (ar_fire),
    .r_last_fire   (r_last_fire),
    .aw_fire       (aw_fire),
    .b_fire        (b_fire),
    .core_reset    (core_reset),
    .axi_gate      (axi_gate),
    .rd_outstanding(rd_outstanding),
    .wr_outstanding(wr_outstanding),
    .proto_err     (proto_err),
    .drain_timeout (drain_timeout),
    .state         (state)
  );

  // Model: state numbers are the published encoding
  // 0 lockwait, 1 hold, 2 run, 3 drain.
  int m_st;
  int m_rd;
  int m_wr;
  int m_in_hold;
  int m_in_drain;
  bit m_perr;
  bit m_tout;
  bit m_lk1;
  bit m_lk2;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int bump(input int v,
                              input bit inc,
                              input bit dec,
                              inout bit err);
    int n;
    n = v + int'(inc) - int'(dec);
    if (n < 0 || n > CMAX) begin
      err = 1'b1;
      n = v;
    end
    return n;
  endfunction

  function void model_reset();
    m_st = 0;
    m_rd = 0;
    m_wr = 0;
    m_in_hold = 0;
    m_in_drain = 0;
    m_perr = 1'b0;
    m_tout = 1'b0;
    m_lk1 = 1'b0;
    m_lk2 = 1'b0;
  endfunction

  function void model_step();
    bit ls;
    int ns;
    ls = m_lk2;
    m_lk2 = m_lk1;
    m_lk1 = mmcm_locked;
    ns = m_st;
    if (m_st == 1) m_in_hold++;
    if (m_st == 3) m_in_drain++;
    case (m_st)
      0: if (ls) ns = 1;
      1: begin
        if (!ls) ns = 0;
        else if (m_in_hold == HOLD) ns = 2;
      end
      2: begin
        if (!ls) ns = 0;
        else if (soft_reset_req) ns = 3;
      end
      default: begin
        if (!ls) ns = 0;
        else if (m_rd == 0 && m_wr == 0) ns = 1;
        else if (TMO_EN && m_in_drain == DTO) begin
          ns = 1;
          m_tout = 1'b1;
        end
      end
    endcase
    if (m_st >= 2) begin
      m_rd = bump(m_rd, ar_fire, r_last_fire, m_perr);
      m_wr = bump(m_wr, aw_fire, b_fire, m_perr);
    end else begin
      m_rd = 0;
      m_wr = 0;
    end
    if (ns != m_st) begin
      m_in_hold = 0;
      m_in_drain = 0;
    end
    m_st = ns;
  endfunction

  task automatic compare_all();
    check("state", state, m_st);
    check("core_reset", core_reset, m_st < 2);
    check("axi_gate", axi_gate, m_st != 2);
    check("rd_outstanding", rd_outstanding, m_rd);
    check("wr_outstanding", wr_outstanding, m_wr);
    check("proto_err", proto_err, m_perr);
    check("drain_timeout", drain_timeout, m_tout);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit ar, input bit rl,
                     input bit aw, input bit b,
                     input bit sr);
    ar_fire = ar;
    r_last_fire = rl;
    aw_fire = aw;
    b_fire = b;
    soft_reset_req = sr;
    tick();
    ar_fire = 1'b0;
    r_last_fire = 1'b0;
    aw_fire = 1'b0;
    b_fire = 1'b0;
    soft_reset_req = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_state", state, 0);
    check("arst_core", core_reset, 1);
    check("arst_gate", axi_gate, 1);
    check("arst_rd", rd_outstanding, 0);
    check("arst_perr", proto_err, 0);
    check("arst_tout", drain_timeout, 0);
    repeat (n) @(posedge clock);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (state !== 2'd2 && n < 200) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    check(tag, state, 2);
  endtask

  initial begin
    int n;
    int down;
    bit ar, rl, aw, b, sr;
    model_reset();
    repeat (5) @(posedge clock);
    #1;
    check("rst_state", state, 0);
    check("rst_core", core_reset, 1);
    check("rst_gate", axi_gate, 1);
    compare_all();
    reset_n = 1'b1;
    repeat (4) cyc(0, 0, 0, 0, 0);

    // Power-up: lock seen through two flops.
    mmcm_locked = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("sync_lat", state, 0);
    cyc(0, 0, 0, 0, 0);
    check("hold_entry", state, 1);
    n = 0;
    while (state === 2'd1 && n < 100) begin
      check("hold_gate", axi_gate, 1);
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    check("hold_len", n, HOLD);
    check("run_core", core_reset, 0);
    check("run_gate", axi_gate, 0);

    // Soft reset with nothing in flight.
    cyc(0, 0, 0, 0, 1);
    check("sr_gate", axi_gate, 1);
    check("sr_drain", state, 3);
    cyc(0, 0, 0, 0, 0);
    check("sr_hold", state, 1);
    check("sr_core", core_reset, 1);
    wait_run("run_after_sr");

    // Drain with outstanding bursts.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("dr_state", state, 3);
    check("dr_rd", rd_outstanding, 3);
    check("dr_wr", wr_outstanding, 2);
    repeat (4) cyc(0, 0, 0, 0, 0);
    check("dr_wait", state, 3);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    check("dr_zero_still", state, 3);
    cyc(0, 0, 0, 0, 0);
    check("dr_exit", state, 1);
    check("dr_core", core_reset, 1);
    wait_run("run_after_drain");

    // Simultaneous inc/dec and underflow.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("simul_rd", rd_outstanding, 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("perr_pre", proto_err, 0);
    cyc(0, 1, 0, 0, 0);
    check("under_rd", rd_outstanding, 0);
    check("under_perr", proto_err, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("perr_sticky", proto_err, 1);

    // Saturation then lock loss with reads in flight.
    repeat (CMAX + 1) cyc(1, 0, 0, 0, 0);
    check("sat_rd", rd_outstanding, CMAX);
    repeat (CMAX - 4) cyc(0, 1, 0, 0, 0);
    check("ll_rd", rd_outstanding, 4);
    mmcm_locked = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("ll_run", state, 2);
    cyc(0, 0, 0, 0, 0);
    check("ll_lockwait", state, 0);
    check("ll_core", core_reset, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    mmcm_locked = 1'b1;
    wait_run("relock_run");
    check("relock_rd", rd_outstanding, 0);

    // Drain with a read that never returns.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("to_drain", state, 3);
    if (TMO_EN) begin
      n = 0;
      while (state === 2'd3 && n < 50) begin
        cyc(0, 0, 0, 0, 0);
        n++;
      end
      check("to_len", n, DTO);
      check("to_flag", drain_timeout, 1);
    end else begin
      repeat (2000) cyc(0, 0, 0, 0, 0);
      check("to_stuck", state, 3);
      check("to_flag0", drain_timeout, 0);
      cyc(0, 1, 0, 0, 0);
    end
    wait_run("run_after_to");

    // Async reset mid-DRAIN.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("ar_pre", state, 3);
    apply_reset(1);
    wait_run("run_after_arst");

    // Random traffic against the model.
    down = 0;
    for (int i = 0; i < 3000; i++) begin
      if (down > 0) begin
        down--;
        if (down == 0) mmcm_locked = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        mmcm_locked = 1'b0;
        down = $urandom_range(8, 1);
      end
      sr = ($urandom_range(15) == 0);
      ar = (m_st == 2 || $urandom_range(39) == 0) &&
           $urandom_range(2) == 0;
      aw = (m_st == 2 || $urandom_range(39) == 0) &&
           $urandom_range(2) == 0;
      rl = (m_rd > 0 || $urandom_range(59) == 0) &&
           $urandom_range(2) == 0;
      b = (m_wr > 0 || $urandom_range(59) == 0) &&
          $urandom_range(2) == 0;
      cyc(ar, rl, aw, b, sr);
      if ($urandom_range(1499) == 0) apply_reset(2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
